// File: rtl/pwm_mon_pkg.sv
// Shared definitions for the multi-channel PWM monitor: channel FSM states
// and the debug-status codes driven onto the bench status bus.
package pwm_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    DONE = 2'd3
  } ch_state_t;

  localparam logic [3:0] DB_RUN  = 4'h0;
  localparam logic [3:0] DB_PASS = 4'ha;
  localparam logic [3:0] DB_FAIL = 4'hf;

endpackage

// File: rtl/pwm_mon_ch.sv
// One PWM monitor channel: edge detect, period/high counters, compare
// against the programmed expectation and sticky pass/fail status.
module pwm_mon_ch
  import pwm_mon_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TOL     = 2,
  parameter int MATCH_N = 4,
  parameter int MISS_N  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm,
  input  logic             enable,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] exp_high,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             ch_pass,
  output logic             ch_fail
);

  localparam int MW = $clog2(MATCH_N + 1);
  localparam int SW = $clog2(MISS_N + 1);
  localparam logic [MW-1:0] MATCH_LIM = MW'(MATCH_N);
  localparam logic [SW-1:0] MISS_LIM = SW'(MISS_N);
  localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);

  ch_state_t        state;
  logic             pwm_d;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [MW-1:0]    match_cnt;
  logic [SW-1:0]    miss_cnt;
  logic             rise, fall, sat, hit;

  function automatic logic in_tol(input logic [CNT_W-1:0] meas, input logic [CNT_W-1:0] expv);
    logic signed [CNT_W:0] diff;
    diff = $signed({1'b0, meas}) - $signed({1'b0, expv});
    if (diff < 0) diff = -diff;
    return diff <= TOL_S;
  endfunction

  // An all-ones period counter means no rise arrived in time: the pad is stuck.
  function automatic logic at_sat(input logic [CNT_W-1:0] cnt);
    return &cnt;
  endfunction

  assign rise = pwm & ~pwm_d;
  assign fall = ~pwm & pwm_d;
  assign sat  = at_sat(per_cnt);
  assign hit  = in_tol(per_cnt, exp_period) && in_tol(meas_high, exp_high);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_d       <= 1'b0;
      state       <= IDLE;
      per_cnt     <= '0;
      hi_cnt      <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      meas_period <= '0;
      meas_high   <= '0;
      ch_pass     <= 1'b0;
      ch_fail     <= 1'b0;
    end else begin
      pwm_d <= pwm;
      if (!enable) begin
        state       <= IDLE;
        per_cnt     <= '0;
        hi_cnt      <= '0;
        match_cnt   <= '0;
        miss_cnt    <= '0;
        meas_period <= '0;
        meas_high   <= '0;
        ch_pass     <= 1'b0;
        ch_fail     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= ARM;
            per_cnt <= '0;
            hi_cnt  <= '0;
          end
          ARM: begin
            if (sat) begin
              ch_fail <= 1'b1;
              state   <= DONE;
            end else if (rise) begin
              state   <= MEAS;
              per_cnt <= CNT_W'(1);
              hi_cnt  <= CNT_W'(1);
            end else begin
              per_cnt <= per_cnt + 1'b1;
            end
          end
          MEAS: begin
            if (sat) begin
              ch_fail <= 1'b1;
              state   <= DONE;
            end else begin
              if (fall) meas_high <= hi_cnt;
              if (rise) begin
                // The rise closes one period and opens the next.
                meas_period <= per_cnt;
                per_cnt     <= CNT_W'(1);
                hi_cnt      <= CNT_W'(1);
                if (hit) begin
                  miss_cnt  <= '0;
                  match_cnt <= match_cnt + 1'b1;
                  if (match_cnt + 1'b1 == MATCH_LIM) begin
                    ch_pass <= 1'b1;
                    state   <= DONE;
                  end
                end else begin
                  match_cnt <= '0;
                  miss_cnt  <= miss_cnt + 1'b1;
                  if (miss_cnt + 1'b1 == MISS_LIM) begin
                    ch_fail <= 1'b1;
                    state   <= DONE;
                  end
                end
              end else begin
                per_cnt <= per_cnt + 1'b1;
                if (pwm) hi_cnt <= hi_cnt + 1'b1;
              end
            end
          end
          DONE: state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/pwm_monitor_mc.sv
// Multi-channel PWM checker: NUM_CH independent channel monitors plus the
// aggregate pass/fail code for the bench debug-status bus.
module pwm_monitor_mc
  import pwm_mon_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int TOL     = 2,
  parameter int MATCH_N = 4,
  parameter int MISS_N  = 3,
  parameter int DB_W    = 4
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [NUM_CH-1:0]       pwm,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*CNT_W-1:0] exp_period,
  input  logic [NUM_CH*CNT_W-1:0] exp_high,
  output logic [NUM_CH*CNT_W-1:0] meas_period,
  output logic [NUM_CH*CNT_W-1:0] meas_high,
  output logic [NUM_CH-1:0]       ch_pass,
  output logic [NUM_CH-1:0]       ch_fail,
  output logic [DB_W-1:0]         db_reg
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_mon_ch #(
      .CNT_W   (CNT_W),
      .TOL     (TOL),
      .MATCH_N (MATCH_N),
      .MISS_N  (MISS_N)
    ) u_ch (
      .clk         (HCLK),
      .rst_n       (HRESETn),
      .pwm         (pwm[i]),
      .enable      (enable[i]),
      .exp_period  (exp_period[i*CNT_W +: CNT_W]),
      .exp_high    (exp_high[i*CNT_W +: CNT_W]),
      .meas_period (meas_period[i*CNT_W +: CNT_W]),
      .meas_high   (meas_high[i*CNT_W +: CNT_W]),
      .ch_pass     (ch_pass[i]),
      .ch_fail     (ch_fail[i])
    );
  end

  // Disabled channels are masked out; a single failing channel overrides pass.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      db_reg <= DB_W'(DB_RUN);
    end else if (|(ch_fail & enable)) begin
      db_reg <= DB_W'(DB_FAIL);
    end else if ((enable != '0) && ((ch_pass & enable) == enable)) begin
      db_reg <= DB_W'(DB_PASS);
    end else begin
      db_reg <= DB_W'(DB_RUN);
    end
  end

endmodule
